// File: rtl/tcp_rt_timer_sched_pkg.sv
// Shared types and constants for the TCP retransmit-timer scheduler.
package tcp_rt_timer_sched_pkg;

    localparam int          MAX_TCP_FLOWS     = 8;
    localparam int          FLOWID_W          = 3;
    localparam int          TIMESTAMP_W       = 32;
    localparam int unsigned RT_TIMEOUT_CYCLES = 250000000;

    typedef struct packed {
        logic [TIMESTAMP_W-1:0] deadline;
        logic                   armed;
    } tx_ack_timer_struct;

    typedef enum logic {
        RT_SCAN = 1'b0,
        RT_REQ  = 1'b1
    } rt_sched_state_e;

    // Deadline arithmetic is modulo 2**TIMESTAMP_W; wrap is not handled.
    function automatic logic [TIMESTAMP_W-1:0] rt_deadline(
        input logic [TIMESTAMP_W-1:0] now,
        input int unsigned            offset
    );
        return now + TIMESTAMP_W'(offset);
    endfunction

endpackage

// File: rtl/tcp_rt_timer_sched_if.sv
// Arm/disarm write ports and the retransmit request handshake.
interface tcp_rt_timer_sched_if;
    import tcp_rt_timer_sched_pkg::*;

    logic                arm_val;
    logic [FLOWID_W-1:0] arm_flowid;
    logic                disarm_val;
    logic [FLOWID_W-1:0] disarm_flowid;
    logic                rt_req_val;
    logic [FLOWID_W-1:0] rt_req_flowid;
    logic                rt_req_rdy;

    modport slave (
        input  arm_val, arm_flowid, disarm_val, disarm_flowid, rt_req_rdy,
        output rt_req_val, rt_req_flowid
    );

    modport master (
        output arm_val, arm_flowid, disarm_val, disarm_flowid, rt_req_rdy,
        input  rt_req_val, rt_req_flowid
    );

endinterface

// File: rtl/tcp_rt_timer_sched_table.sv
// Per-flow timer storage: arm > disarm > scan-clear, one combinational read port.
module tcp_rt_timer_table
    import tcp_rt_timer_sched_pkg::*;
#(
    parameter int NUM_FLOWS = MAX_TCP_FLOWS,
    parameter int PTR_W     = FLOWID_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_arm_val,
    input  logic [PTR_W-1:0]       i_arm_idx,
    input  logic [TIMESTAMP_W-1:0] i_arm_deadline,
    input  logic                   i_disarm_val,
    input  logic [PTR_W-1:0]       i_disarm_idx,
    input  logic                   i_clr_val,
    input  logic [PTR_W-1:0]       i_clr_idx,
    input  logic [PTR_W-1:0]       i_rd_idx,
    output tx_ack_timer_struct     o_rd_entry,
    output logic [NUM_FLOWS-1:0]   o_armed_vec
);

    tx_ack_timer_struct r_tbl [NUM_FLOWS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_FLOWS; i++) begin
                r_tbl[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FLOWS; i++) begin
                if (i_arm_val && (i_arm_idx == PTR_W'(i))) begin
                    r_tbl[i].deadline <= i_arm_deadline;
                    r_tbl[i].armed    <= 1'b1;
                end else if (i_disarm_val && (i_disarm_idx == PTR_W'(i))) begin
                    r_tbl[i].armed <= 1'b0;
                end else if (i_clr_val && (i_clr_idx == PTR_W'(i))) begin
                    r_tbl[i].armed <= 1'b0;
                end
            end
        end
    end

    assign o_rd_entry = r_tbl[i_rd_idx];

    always_comb begin
        o_armed_vec = '0;
        for (int i = 0; i < NUM_FLOWS; i++) begin
            o_armed_vec[i] = r_tbl[i].armed;
        end
    end

endmodule

// File: rtl/tcp_rt_timer_sched.sv
// Round-robin retransmit-timer scanner issuing one request at a time to TX.
module tcp_rt_timer_sched
    import tcp_rt_timer_sched_pkg::*;
#(
    parameter int          NUM_FLOWS      = MAX_TCP_FLOWS,
    parameter int unsigned TIMEOUT_CYCLES = RT_TIMEOUT_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    tcp_rt_timer_sched_if.slave    rt_if,
    output logic [TIMESTAMP_W-1:0] o_curr_time,
    output logic [NUM_FLOWS-1:0]   o_armed_vec
);

    localparam int PTR_W = (NUM_FLOWS > 1) ? $clog2(NUM_FLOWS) : 1;

    rt_sched_state_e        r_state;
    rt_sched_state_e        w_state_nxt;
    logic [PTR_W-1:0]       r_scan_ptr;
    logic [TIMESTAMP_W-1:0] r_curr_time;
    logic [FLOWID_W-1:0]    r_req_flowid;
    logic [PTR_W-1:0]       w_arm_idx;
    logic [PTR_W-1:0]       w_disarm_idx;
    tx_ack_timer_struct     w_entry;
    logic                   w_conflict;
    logic                   w_expired;
    logic                   w_fire;
    logic                   w_adv;

    assign w_arm_idx    = rt_if.arm_flowid[PTR_W-1:0];
    assign w_disarm_idx = rt_if.disarm_flowid[PTR_W-1:0];

    tcp_rt_timer_table #(
        .NUM_FLOWS (NUM_FLOWS),
        .PTR_W     (PTR_W)
    ) u_table (
        .clk            (clk),
        .rst            (rst),
        .i_arm_val      (rt_if.arm_val),
        .i_arm_idx      (w_arm_idx),
        .i_arm_deadline (rt_deadline(r_curr_time, TIMEOUT_CYCLES)),
        .i_disarm_val   (rt_if.disarm_val),
        .i_disarm_idx   (w_disarm_idx),
        .i_clr_val      (w_fire),
        .i_clr_idx      (r_scan_ptr),
        .i_rd_idx       (r_scan_ptr),
        .o_rd_entry     (w_entry),
        .o_armed_vec    (o_armed_vec)
    );

    // A concurrent write to the scanned entry wins; the fire is dropped, not retried.
    assign w_conflict = (rt_if.arm_val    && (w_arm_idx    == r_scan_ptr)) ||
                        (rt_if.disarm_val && (w_disarm_idx == r_scan_ptr));
    assign w_expired  = w_entry.armed && (r_curr_time >= w_entry.deadline) && !w_conflict;

    always_comb begin
        w_state_nxt = r_state;
        w_fire      = 1'b0;
        w_adv       = 1'b0;
        case (r_state)
            RT_SCAN: begin
                if (w_expired) begin
                    w_fire      = 1'b1;
                    w_state_nxt = RT_REQ;
                end else begin
                    w_adv = 1'b1;
                end
            end
            RT_REQ: begin
                if (rt_if.rt_req_rdy) begin
                    w_adv       = 1'b1;
                    w_state_nxt = RT_SCAN;
                end
            end
            default: w_state_nxt = RT_SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RT_SCAN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_curr_time  <= '0;
            r_scan_ptr   <= '0;
            r_req_flowid <= '0;
        end else begin
            r_curr_time <= r_curr_time + 1'b1;
            if (w_adv) begin
                r_scan_ptr <= r_scan_ptr + 1'b1;
            end
            if (w_fire) begin
                r_req_flowid <= FLOWID_W'(r_scan_ptr);
            end
        end
    end

    assign rt_if.rt_req_val    = (r_state == RT_REQ);
    assign rt_if.rt_req_flowid = r_req_flowid;
    assign o_curr_time         = r_curr_time;

endmodule
